// File: rtl/tlc_intersection_if.sv
// Control and lamp bundle for tlc_intersection: run/pedestrian inputs, lamp and status outputs.
// The master side drives on/ped_req; the slave side (the controller) drives the lamps.
interface tlc_intersection_if #(
    parameter int unsigned N_DIR = 2,
    parameter int unsigned PH_W  = ($clog2(N_DIR) > 1) ? $clog2(N_DIR) : 1
);
    logic             on;
    logic [N_DIR-1:0] ped_req;
    logic [N_DIR-1:0] r;
    logic [N_DIR-1:0] y;
    logic [N_DIR-1:0] g;
    logic [N_DIR-1:0] walk;
    logic [PH_W-1:0]  phase;
    logic             cycle_done;

    modport master (
        output on, ped_req,
        input  r, y, g, walk, phase, cycle_done
    );

    modport slave (
        input  on, ped_req,
        output r, y, g, walk, phase, cycle_done
    );
endinterface

// File: rtl/tlc_intersection.sv
// Round-robin multi-approach traffic light controller with all-red clearance.
// Define TLC_PED_EN to enable pedestrian service (walk lamps and green extension).
module tlc_intersection #(
    parameter int unsigned N_DIR     = 2,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned T_GREEN   = 5,
    parameter int unsigned T_YELLOW  = 2,
    parameter int unsigned T_ALLRED  = 1,
    parameter int unsigned T_PED_EXT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    tlc_intersection_if.slave bus
);
    localparam int unsigned     PH_W    = ($clog2(N_DIR) > 1) ? $clog2(N_DIR) : 1;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] GX_LAST = CNT_W'(T_GREEN + T_PED_EXT - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(T_ALLRED - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(N_DIR - 1);

    // Parameter legality, rejected at elaboration
    if (N_DIR < 2) begin : g_bad_ndir
        $fatal(1, "tlc_intersection: N_DIR must be at least 2");
    end
    if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1) begin : g_bad_min
        $fatal(1, "tlc_intersection: T_GREEN, T_YELLOW and T_ALLRED must be at least 1");
    end
    if (64'(T_GREEN) > CNT_MAX || 64'(T_YELLOW) > CNT_MAX || 64'(T_ALLRED) > CNT_MAX) begin : g_bad_fit
        $fatal(1, "tlc_intersection: a dwell does not fit in CNT_W bits");
    end
    if (64'(T_GREEN) + 64'(T_PED_EXT) > CNT_MAX) begin : g_bad_ext
        $fatal(1, "tlc_intersection: T_GREEN+T_PED_EXT does not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;

    logic [N_DIR-1:0] r_q, r_d;
    logic [N_DIR-1:0] y_q, y_d;
    logic [N_DIR-1:0] g_q, g_d;
    logic [N_DIR-1:0] walk_q, walk_d;
    logic [PH_W-1:0]  phase_q;
    logic             cycle_done_q, cycle_done_d;

    logic             svc;
    logic [CNT_W-1:0] green_last;

    assign green_last = svc ? GX_LAST : G_LAST;

    // Next state, dwell counter, phase advance and next lamp pattern
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ph_d    = ph_q;
        r_d     = '1;
        y_d     = '0;
        g_d     = '0;

        case (state_q)
            IDLE: begin
                if (bus.on) state_d = GREEN;
            end
            GREEN: begin
                if (cnt_q == green_last) state_d = YELLOW;
                else                     cnt_d   = cnt_q + CNT_W'(1);
            end
            YELLOW: begin
                if (cnt_q == Y_LAST) state_d = ALLRED;
                else                 cnt_d   = cnt_q + CNT_W'(1);
            end
            ALLRED: begin
                if (cnt_q == AR_LAST) begin
                    ph_d    = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
                    state_d = bus.on ? GREEN : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int k = 0; k < N_DIR; k++) begin
            g_d[k] = (PH_W'(k) == ph_d) && (state_d == GREEN);
            y_d[k] = (PH_W'(k) == ph_d) && (state_d == YELLOW);
            r_d[k] = !(g_d[k] || y_d[k]);
        end

        cycle_done_d = (state_d == ALLRED) && (cnt_d == AR_LAST) && (ph_d == PH_LAST);
    end

`ifdef TLC_PED_EN
    logic             svc_q, svc_d;
    logic [N_DIR-1:0] pend_q, pend_d;

    assign svc = svc_q;

    // Pending requests latch until their phase's green entry; the entry edge's own request joins the service
    always_comb begin
        pend_d = pend_q | bus.ped_req;
        svc_d  = svc_q;
        walk_d = '0;

        if (state_d == GREEN && state_q != GREEN) begin
            svc_d = 1'b0;
            for (int k = 0; k < N_DIR; k++) begin
                if (PH_W'(k) == ph_d) begin
                    svc_d     = pend_q[k] | bus.ped_req[k];
                    pend_d[k] = 1'b0;
                end
            end
        end else if (state_d != GREEN) begin
            svc_d = 1'b0;
        end

        for (int k = 0; k < N_DIR; k++) begin
            walk_d[k] = svc_d && (state_d == GREEN) && (PH_W'(k) == ph_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            svc_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            svc_q  <= svc_d;
            pend_q <= pend_d;
        end
    end
`else
    logic unused_ped;

    assign unused_ped = ^bus.ped_req;
    assign svc        = 1'b0;
    assign walk_d     = '0;
`endif

    // State and registered outputs; reset parks everything all-red at phase 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ph_q         <= '0;
            r_q          <= '1;
            y_q          <= '0;
            g_q          <= '0;
            walk_q       <= '0;
            phase_q      <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ph_q         <= ph_d;
            r_q          <= r_d;
            y_q          <= y_d;
            g_q          <= g_d;
            walk_q       <= walk_d;
            phase_q      <= ph_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign bus.r          = r_q;
    assign bus.y          = y_q;
    assign bus.g          = g_q;
    assign bus.walk       = walk_q;
    assign bus.phase      = phase_q;
    assign bus.cycle_done = cycle_done_q;
endmodule

// File: tb/tb_tlc_intersection.sv
// Directed bench for tlc_intersection (N_DIR=2 defaults) plus a random N_DIR=4 lamp-invariant run.
module tb_tlc_intersection;
    localparam int T_Y  = 2;
    localparam int T_AR = 1;
`ifdef TLC_PED_EN
    localparam bit PED  = 1'b1;
`else
    localparam bit PED  = 1'b0;
`endif
    localparam int G_PED = PED ? 8 : 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tlc_intersection_if #(.N_DIR(2)) bus ();
    tlc_intersection_if #(.N_DIR(4)) bus4 ();

    tlc_intersection #(.N_DIR(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    tlc_intersection #(.N_DIR(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obs_vec();
        return 16'({bus.r, bus.y, bus.g, bus.walk, bus.phase, bus.cycle_done});
    endfunction

    function automatic logic [15:0] vec(input logic [1:0] r, input logic [1:0] y, input logic [1:0] g,
                                        input logic [1:0] w, input logic ph, input logic cd);
        return 16'({r, y, g, w, ph, cd});
    endfunction

    // One full phase: green (glen), yellow, all-red; optional ped pulse and on-drop after cycle i
    task automatic phase_chk(input int ph, input int glen, input bit wk,
                             input int inj_at, input logic [1:0] inj_val, input int drop_at);
        logic [1:0] er, ey, eg, ew;
        logic       ecd;
        for (int i = 1; i <= glen + T_Y + T_AR; i++) begin
            tick();
            er  = 2'b11;
            ey  = 2'b00;
            eg  = 2'b00;
            ew  = 2'b00;
            ecd = 1'b0;
            if (i <= glen) begin
                eg = 2'(1 << ph);
                er = ~eg;
                if (wk) ew = eg;
            end else if (i <= glen + T_Y) begin
                ey = 2'(1 << ph);
                er = ~ey;
            end else begin
                ecd = (ph == 1) && (i == glen + T_Y + T_AR);
            end
            check($sformatf("ph%0d_c%0d", ph, i), obs_vec(), vec(er, ey, eg, ew, 1'(ph), ecd));
            bus.ped_req = (i == inj_at) ? inj_val : 2'b00;
            if (i == drop_at) bus.on = 1'b0;
        end
        bus.ped_req = 2'b00;
    endtask

    initial begin
        logic ok;
        int   nonred;

        bus.on       = 1'b0;
        bus.ped_req  = 2'b00;
        bus4.on      = 1'b0;
        bus4.ped_req = 4'b0000;
        rst_n        = 1'b0;
        repeat (2) tick();
        check("reset_state", obs_vec(), vec(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

        // Basic rotation from reset release: cycles 1-24
        rst_n  = 1'b1;
        bus.on = 1'b1;
        phase_chk(0, 5, 1'b0, 0, 2'b00, 0);
        phase_chk(1, 5, 1'b0, 0, 2'b00, 0);
        phase_chk(0, 5, 1'b0, 0, 2'b00, 0);

        // Reset asserted mid-yellow of phase 1
        repeat (6) tick();
        check("pre_reset_yellow", obs_vec(), vec(2'b01, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs_vec(), vec(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        bus.on = 1'b0;
        tick();
        check("reset_held", obs_vec(), vec(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_idle%0d", i), obs_vec(), vec(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        end

        // Stop during green cycle 3: phase completes, then idles at the advanced phase
        bus.on = 1'b1;
        phase_chk(0, 5, 1'b0, 0, 2'b00, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stopped_idle%0d", i), obs_vec(), vec(2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
        end
        bus.on = 1'b1;
        phase_chk(1, 5, 1'b0, 0, 2'b00, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("resume_idle%0d", i), obs_vec(), vec(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        end

        // Pedestrian service: extension, same-edge request, own-green request
        bus.on = 1'b1;
        phase_chk(0, 5,     1'b0, 2, 2'b10, 0);
        phase_chk(1, G_PED, PED,  0, 2'b00, 0);
        phase_chk(0, 5,     1'b0, 0, 2'b00, 0);
        phase_chk(1, 5,     1'b0, 8, 2'b01, 0);
        phase_chk(0, G_PED, PED,  3, 2'b01, 0);
        phase_chk(1, 5,     1'b0, 0, 2'b00, 0);
        phase_chk(0, G_PED, PED,  0, 2'b00, 0);
        phase_chk(1, 5,     1'b0, 0, 2'b00, 0);
        phase_chk(0, 5,     1'b0, 0, 2'b00, 8);
        tick();
        check("final_idle", obs_vec(), vec(2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));

        // Lamp invariant on a four-approach controller under random stimulus
        for (int c = 0; c < 3000; c++) begin
            bus4.on      = ($urandom_range(0, 7) != 0);
            bus4.ped_req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick();
            ok     = 1'b1;
            nonred = 0;
            for (int k = 0; k < 4; k++) begin
                if ((int'(bus4.r[k]) + int'(bus4.y[k]) + int'(bus4.g[k])) != 1) ok = 1'b0;
                if (!bus4.r[k]) nonred++;
            end
            if (nonred > 1) ok = 1'b0;
            if ((bus4.walk & ~bus4.g) != 4'b0000) ok = 1'b0;
            check($sformatf("inv4_c%0d", c), 16'(ok), 16'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
